// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - pipeline-facing signal bundle for the coprocessor-0 unit
interface cp0_unit_if;
  logic        cu_cp0_w_en;
  logic [4:0]  cu_exec_code;
  logic [31:0] cu_epc;
  logic        exmem_eret;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic [5:0]  hw_intr;
  logic        cp0_intr;
  logic [31:0] cp0_epc;

  modport master (
    output cu_cp0_w_en, cu_exec_code, cu_epc, exmem_eret,
    output mtc0_en, mtc0_addr, mtc0_data, mfc0_addr, hw_intr,
    input  mfc0_data, cp0_intr, cp0_epc
  );

  modport slave (
    input  cu_cp0_w_en, cu_exec_code, cu_epc, exmem_eret,
    input  mtc0_en, mtc0_addr, mtc0_data, mfc0_addr, hw_intr,
    output mfc0_data, cp0_intr, cp0_epc
  );
endinterface

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 Status/Cause/EPC registers, interrupt request, optional Count/Compare timer
// Defining CP0_TIMER_EN adds the Count/Compare timer and the TI interrupt source.
module cp0_unit #(
  parameter int unsigned COUNT_DIV_LOG2 = 1,
  parameter logic [31:0] STATUS_RESET   = 32'h0000_0000
) (
  input logic   clk,
  input logic   reset,
  cp0_unit_if.slave bus
);
  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  logic        ie_q, ie_d, exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  exc_q, exc_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  hw_q;
  logic [31:0] epc_q, epc_d;
  logic        ti;
  logic [31:0] count_rd, compare_rd;
  logic [7:0]  ip;

  logic wr_status, wr_cause, wr_epc;
  assign wr_status = bus.mtc0_en && (bus.mtc0_addr == ADDR_STATUS);
  assign wr_cause  = bus.mtc0_en && (bus.mtc0_addr == ADDR_CAUSE);
  assign wr_epc    = bus.mtc0_en && (bus.mtc0_addr == ADDR_EPC);

  // Exception entry owns EPC/ExcCode/EXL; eret only overrides EXL from an mtc0.
  always_comb begin
    ie_d    = ie_q;
    exl_d   = exl_q;
    im_d    = im_q;
    exc_d   = exc_q;
    ip_sw_d = ip_sw_q;
    epc_d   = epc_q;
    if (wr_status) begin
      ie_d  = bus.mtc0_data[0];
      exl_d = bus.mtc0_data[1];
      im_d  = bus.mtc0_data[15:8];
    end
    if (wr_cause) ip_sw_d = bus.mtc0_data[9:8];
    if (wr_epc)   epc_d   = bus.mtc0_data;
    if (bus.cu_cp0_w_en) begin
      epc_d = bus.cu_epc;
      exc_d = bus.cu_exec_code;
      exl_d = 1'b1;
    end else if (bus.exmem_eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q    <= STATUS_RESET[0];
      exl_q   <= STATUS_RESET[1];
      im_q    <= STATUS_RESET[15:8];
      exc_q   <= 5'd0;
      ip_sw_q <= 2'd0;
      hw_q    <= 6'd0;
      epc_q   <= 32'd0;
    end else begin
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      exc_q   <= exc_d;
      ip_sw_q <= ip_sw_d;
      hw_q    <= bus.hw_intr;
      epc_q   <= epc_d;
    end
  end

`ifdef CP0_TIMER_EN
  localparam int unsigned DIV_W = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;

  logic [31:0]      count_q, count_d, compare_q, compare_d;
  logic [DIV_W-1:0] div_q;
  logic             ti_q, ti_d, tick;
  logic             wr_count, wr_compare;

  assign wr_count   = bus.mtc0_en && (bus.mtc0_addr == ADDR_COUNT);
  assign wr_compare = bus.mtc0_en && (bus.mtc0_addr == ADDR_COMPARE);
  assign tick       = (COUNT_DIV_LOG2 == 0) ? 1'b1 : (&div_q);

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wr_count)  count_d = bus.mtc0_data;
    else if (tick) count_d = count_q + 32'd1;
    if (wr_compare) begin
      compare_d = bus.mtc0_data;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      div_q     <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      div_q     <= div_q + DIV_W'(1);
      ti_q      <= ti_d;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
`endif

  assign ip           = {hw_q[5] | ti, hw_q[4:0], ip_sw_q};
  assign bus.cp0_intr = ie_q & ~exl_q & (|(ip & im_q));
  assign bus.cp0_epc  = epc_q;

  always_comb begin
    bus.mfc0_data = 32'd0;
    case (bus.mfc0_addr)
      ADDR_COUNT:   bus.mfc0_data = count_rd;
      ADDR_COMPARE: bus.mfc0_data = compare_rd;
      ADDR_STATUS:  bus.mfc0_data = {16'd0, im_q, 6'd0, exl_q, ie_q};
      ADDR_CAUSE:   bus.mfc0_data = {1'b0, ti, 14'd0, ip, 1'b0, exc_q, 2'd0};
      ADDR_EPC:     bus.mfc0_data = epc_q;
      default:      bus.mfc0_data = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed self-checking bench for cp0_unit
module tb_cp0_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  cp0_unit_if bus ();

  cp0_unit #(.COUNT_DIV_LOG2(1), .STATUS_RESET(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.mtc0_en   = 1'b1;
    bus.mtc0_addr = addr;
    bus.mtc0_data = data;
    tick();
    bus.mtc0_en   = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, output logic [31:0] data);
    bus.mfc0_addr = addr;
    #1;
    data = bus.mfc0_data;
  endtask

  logic [31:0] v;
  logic [31:0] c;
  logic        found;
  logic        seen0;

  initial begin
    total = 0;
    bad   = 0;
    bus.cu_cp0_w_en  = 1'b0;
    bus.cu_exec_code = 5'd0;
    bus.cu_epc       = 32'd0;
    bus.exmem_eret   = 1'b0;
    bus.mtc0_en      = 1'b0;
    bus.mtc0_addr    = 5'd0;
    bus.mtc0_data    = 32'd0;
    bus.mfc0_addr    = 5'd0;
    bus.hw_intr      = 6'd0;
    reset = 1'b1;
    tick();
    tick();

    rd(12, v); check("rst_status", v, 32'h0);
    rd(13, v); check("rst_cause", v, 32'h0);
    rd(14, v); check("rst_epc", v, 32'h0);
`ifdef CP0_TIMER_EN
    rd(9, v);  check("rst_count", v, 32'h0);
    rd(11, v); check("rst_compare", v, 32'hFFFF_FFFF);
`else
    rd(11, v); check("rst_compare", v, 32'h0);
`endif
    check("rst_intr", 32'(bus.cp0_intr), 32'd0);
    check("rst_cp0_epc", bus.cp0_epc, 32'h0);
    reset = 1'b0;

    // Interrupt from hw line 0 through IM[2]
    bus.hw_intr = 6'b000001;
    mtc0(12, 32'h0000_0401);
    tick();
    check("hw_intr_req", 32'(bus.cp0_intr), 32'd1);

    // Exception entry; mfc0 in the same cycle still sees the old EPC
    bus.cu_cp0_w_en  = 1'b1;
    bus.cu_exec_code = 5'd0;
    bus.cu_epc       = 32'h8000_0040;
    rd(14, v); check("mfc0_old_epc", v, 32'h0);
    tick();
    bus.cu_cp0_w_en = 1'b0;
    rd(12, v); check("entry_status", v, 32'h0000_0403);
    check("entry_intr", 32'(bus.cp0_intr), 32'd0);
    check("entry_epc", bus.cp0_epc, 32'h8000_0040);
    rd(13, v); check("entry_cause", v, 32'h0000_0400);

    // w_en beats eret
    bus.cu_cp0_w_en  = 1'b1;
    bus.cu_exec_code = 5'd8;
    bus.cu_epc       = 32'h0000_1234;
    bus.exmem_eret   = 1'b1;
    tick();
    bus.cu_cp0_w_en = 1'b0;
    bus.exmem_eret  = 1'b0;
    rd(12, v); check("wen_eret_status", v, 32'h0000_0403);
    rd(13, v); check("wen_eret_cause", v, 32'h0000_0420);

    bus.exmem_eret = 1'b1;
    tick();
    bus.exmem_eret = 1'b0;
    rd(12, v); check("eret_status", v, 32'h0000_0401);
    check("eret_intr", 32'(bus.cp0_intr), 32'd1);

    // w_en beats mtc0 EPC
    bus.cu_cp0_w_en  = 1'b1;
    bus.cu_exec_code = 5'd0;
    bus.cu_epc       = 32'h0000_2000;
    mtc0(14, 32'h0000_DEAD);
    bus.cu_cp0_w_en = 1'b0;
    check("wen_mtc0_epc", bus.cp0_epc, 32'h0000_2000);
    rd(12, v); check("wen_mtc0_status", v, 32'h0000_0403);

    // eret beats mtc0 for EXL, IE/IM still written
    bus.exmem_eret = 1'b1;
    mtc0(12, 32'h0000_0403);
    bus.exmem_eret = 1'b0;
    rd(12, v); check("eret_mtc0_status", v, 32'h0000_0401);

    bus.hw_intr = 6'd0;
    tick();
    check("hw_drop_intr", 32'(bus.cp0_intr), 32'd0);
    rd(13, v); check("hw_drop_cause", v, 32'h0);

    // Status write mask, software interrupt
    mtc0(12, 32'hFFFF_FFFF);
    rd(12, v); check("status_mask", v, 32'h0000_FF03);
    rd(5, v);  check("unmapped_rd", v, 32'h0);
    mtc0(12, 32'h0000_0201);
    mtc0(13, 32'hFFFF_0200);
    rd(13, v); check("sw_cause", v, 32'h0000_0200);
    check("sw_intr", 32'(bus.cp0_intr), 32'd1);
    mtc0(13, 32'h0);
    check("sw_clear_intr", 32'(bus.cp0_intr), 32'd0);

`ifdef CP0_TIMER_EN
    mtc0(9, 32'hFFFF_FFFE);
    mtc0(11, 32'h0000_0001);
    mtc0(12, 32'h0000_8001);
    found = 1'b0;
    seen0 = 1'b0;
    c     = 32'h0;
    for (int i = 0; i < 40; i++) begin
      rd(9, c);
      if (c == 32'h0) seen0 = 1'b1;
      rd(13, v);
      if (v[30]) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("ti_rise", 32'(found), 32'd1);
    check("ti_count", c, 32'h1);
    check("count_wrap", 32'(seen0), 32'd1);
    check("ti_intr", 32'(bus.cp0_intr), 32'd1);
    mtc0(11, 32'h0000_0005);
    rd(13, v); check("ti_clear_cause", v, 32'h0);
    check("ti_clear_intr", 32'(bus.cp0_intr), 32'd0);
    mtc0(11, 32'h0000_0010);
    mtc0(9, 32'h0000_0010);
    tick();
    rd(13, v); check("ti_reset_prep", v, 32'h4000_8000);
`else
    mtc0(9, 32'h0000_1234);
    rd(9, v);  check("count_absent", v, 32'h0);
    mtc0(11, 32'h0000_0005);
    rd(11, v); check("compare_absent", v, 32'h0);
    mtc0(12, 32'h0000_8001);
`endif

    // Reset while EXL=1
    bus.cu_cp0_w_en  = 1'b1;
    bus.cu_exec_code = 5'd0;
    bus.cu_epc       = 32'h0000_3000;
    tick();
    bus.cu_cp0_w_en = 1'b0;
    rd(12, v); check("pre_rst_status", v, 32'h0000_8003);
    reset = 1'b1;
    tick();
    rd(12, v); check("mid_rst_status", v, 32'h0);
    rd(13, v); check("mid_rst_cause", v, 32'h0);
    rd(14, v); check("mid_rst_epc", v, 32'h0);
`ifdef CP0_TIMER_EN
    rd(9, v);  check("mid_rst_count", v, 32'h0);
    rd(11, v); check("mid_rst_compare", v, 32'hFFFF_FFFF);
`endif
    check("mid_rst_intr", 32'(bus.cp0_intr), 32'd0);
    check("mid_rst_cp0_epc", bus.cp0_epc, 32'h0);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
